// File: rtl/pipeline_stall_controller_pkg.sv
// pipeline_stall_controller_pkg: shared state encodings, defaults and control-bundle helpers.
// Contents: state_t (RUN/MUL_BUSY/DMEM_WAIT), default parameters, ctl_t bundle of the
// eight per-stage enable/flush controls and the fixed control patterns used by the sequencer.
package pipeline_stall_controller_pkg;
   localparam int REGISTER_BITS    = 32;
   localparam int DEF_MUL_LATENCY  = 4;
   localparam int DEF_DMEM_TIMEOUT = 64;
   typedef enum logic [1:0] {
      RUN       = 2'd0,
      MUL_BUSY  = 2'd1,
      DMEM_WAIT = 2'd2
   } state_t;
   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic id_ex_en;
      logic ex_mem_en;
      logic mem_wb_en;
      logic if_id_flush;
      logic id_ex_flush;
      logic ex_mem_flush;
   } ctl_t;
   localparam ctl_t CTL_RESET  = 8'b00000_111;
   localparam ctl_t CTL_FREEZE = 8'b00000_000;
   localparam ctl_t CTL_RUN    = 8'b11111_000;
   // Hold upstream, push a bubble into EX/MEM, let MEM/WB drain.
   localparam ctl_t CTL_MUL    = 8'b00011_001;
   // Hold PC and IF/ID, push a bubble into ID/EX.
   localparam ctl_t CTL_HOLD   = 8'b00111_010;
   // Fetch-side bubble: IF/ID takes a flush, PC advances only when told to.
   function automatic ctl_t fetch_ctl(input logic pc_en);
      return {pc_en, 7'b1111_100};
   endfunction
endpackage

// File: rtl/pipeline_stall_controller_if.sv
// pipeline_stall_controller_if: request inputs and per-stage controls of the stall sequencer.
// master: hazard unit / memories / multiplier side (drives requests, sees controls).
// slave : the sequencer (sees requests, drives enables, flushes, mul_busy, bus_error, stall_count).
import pipeline_stall_controller_pkg::*;
interface pipeline_stall_controller_if #(parameter int CNT_BITS = REGISTER_BITS);
   logic hold_req, id_flush_req, ex_flush_req, branch_taken;
   logic imem_ready, dmem_req, dmem_ready, mul_start;
   logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic if_id_flush, id_ex_flush, ex_mem_flush;
   logic mul_busy, bus_error;
   logic [CNT_BITS-1:0] stall_count;
   modport master (
      output hold_req, id_flush_req, ex_flush_req, branch_taken,
      output imem_ready, dmem_req, dmem_ready, mul_start,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
      input  if_id_flush, id_ex_flush, ex_mem_flush,
      input  mul_busy, bus_error, stall_count
   );
   modport slave (
      input  hold_req, id_flush_req, ex_flush_req, branch_taken,
      input  imem_ready, dmem_req, dmem_ready, mul_start,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
      output if_id_flush, id_ex_flush, ex_mem_flush,
      output mul_busy, bus_error, stall_count
   );
endinterface

// File: rtl/pipeline_stall_controller_stall_counter_sat.sv
// stall_counter_sat: CNT_BITS-wide up-counter that sticks at all-ones.
// Ports: clk, rst (sync, active-high), clr (sync clear), en (count this cycle), count.
import pipeline_stall_controller_pkg::*;
module stall_counter_sat #(
   parameter int CNT_BITS = REGISTER_BITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                en,
   output logic [CNT_BITS-1:0] count
);
   always_ff @(posedge clk)
      if (rst || clr) count <= '0;
      else if (en && count != '1) count <= count + CNT_BITS'(1);
endmodule

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: sequences pc/IF-ID/ID-EX/EX-MEM/MEM-WB enables and flushes.
// Ports: clk, rst (sync, active-high), bus (slave modport): hazard/branch/memory/multiplier
// requests in; stage enables, bubble flushes, mul_busy, sticky bus_error and saturating
// stall_count out.
import pipeline_stall_controller_pkg::*;
module pipeline_stall_controller #(
   parameter int MUL_LATENCY  = DEF_MUL_LATENCY,
   parameter int DMEM_TIMEOUT = DEF_DMEM_TIMEOUT,
   parameter int CNT_BITS     = REGISTER_BITS
) (
   input logic clk,
   input logic rst,
   pipeline_stall_controller_if.slave bus
);
   localparam int MCW = $clog2(MUL_LATENCY + 1);
   localparam int TW  = $clog2(DMEM_TIMEOUT + 1) + 1;
   localparam logic [MCW-1:0] MUL_LOAD = MCW'(MUL_LATENCY - 2);
   // Registered flag appears one cycle after the compare, so trip one count early.
   localparam logic [TW-1:0]  TMO_SET  = TW'(DMEM_TIMEOUT - 2);
   localparam bit MUL_STALLS = MUL_LATENCY > 1;
   state_t state;
   logic [MCW-1:0] mul_cnt, mul_cnt_nxt;
   logic [TW-1:0] tmo_cnt;
   logic [CNT_BITS-1:0] stall_q;
   logic mul_served, drop_next, drop_nxt, bus_err_q;
   logic dwait, run_like, mul_go, in_mul, advance;
   ctl_t run_ctl, ctl;
   // Once in DMEM_WAIT only dmem_ready ends the wait; elsewhere a pending access freezes.
   assign dwait    = (state == DMEM_WAIT) ? !bus.dmem_ready : bus.dmem_req && !bus.dmem_ready;
   assign run_like = !dwait && state != MUL_BUSY;
   assign mul_go   = bus.mul_start && !mul_served && MUL_STALLS;
   assign in_mul   = (state == MUL_BUSY && !dwait) || (run_like && mul_go);
   // mul_cnt holds the MUL_BUSY cycles still to come; reaching zero returns to RUN.
   assign mul_cnt_nxt = (state == MUL_BUSY) ? mul_cnt - MCW'(1) : MUL_LOAD;
   always_comb begin
      run_ctl  = CTL_RUN;
      drop_nxt = drop_next;
      if (mul_go || bus.ex_flush_req) run_ctl = CTL_MUL;
      else if (bus.hold_req || bus.id_flush_req) run_ctl = CTL_HOLD;
      else if (bus.branch_taken) begin
         run_ctl  = fetch_ctl(1'b1);
         drop_nxt = !bus.imem_ready;
      end else if (!bus.imem_ready || drop_next) begin
         run_ctl  = fetch_ctl(bus.imem_ready);
         drop_nxt = drop_next && !bus.imem_ready;
      end
   end
   assign ctl = rst ? CTL_RESET : dwait ? CTL_FREEZE : (state == MUL_BUSY) ? CTL_MUL : run_ctl;
   assign advance = ctl.id_ex_en && ctl.ex_mem_en && !ctl.ex_mem_flush;
   always_ff @(posedge clk)
      if (rst) begin
         state      <= RUN;
         mul_cnt    <= '0;
         mul_served <= 1'b0;
         drop_next  <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state <= dwait ? ((state == MUL_BUSY) ? MUL_BUSY : DMEM_WAIT)
                : (in_mul && mul_cnt_nxt != '0) ? MUL_BUSY : RUN;
         mul_cnt    <= in_mul ? mul_cnt_nxt : mul_cnt;
         mul_served <= (in_mul && mul_cnt_nxt == '0) ? 1'b1 : advance ? 1'b0 : mul_served;
         drop_next  <= run_like ? drop_nxt : drop_next;
         bus_err_q  <= bus_err_q || (dwait && tmo_cnt >= TMO_SET);
      end
   stall_counter_sat #(.CNT_BITS(TW)) u_tmo (
      .clk(clk), .rst(rst), .clr(!dwait), .en(dwait), .count(tmo_cnt)
   );
   stall_counter_sat #(.CNT_BITS(CNT_BITS)) u_stall (
      .clk(clk), .rst(rst), .clr(1'b0), .en(!ctl.pc_en), .count(stall_q)
   );
   assign {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
           bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush} = ctl;
   assign bus.mul_busy    = !rst && state == MUL_BUSY;
   assign bus.bus_error   = !rst && bus_err_q;
   assign bus.stall_count = rst ? '0 : stall_q;
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller: directed vector table plus randomized run against a reference model.
module tb_pipeline_stall_controller;
   localparam int ML = 4;
   localparam int DT = 8;
   localparam logic [7:0] C_RST = 8'b00000_111;
   localparam logic [7:0] C_RUN = 8'b11111_000;
   localparam logic [7:0] C_FRZ = 8'b00000_000;
   localparam logic [7:0] C_MUL = 8'b00011_001;
   localparam logic [7:0] C_HLD = 8'b00111_010;
   localparam logic [7:0] C_BR  = 8'b11111_100;
   localparam logic [7:0] C_FW  = 8'b01111_100;
   localparam logic [8:0] Q     = 9'b0_0000_1000;
   logic clk = 1'b0;
   logic rst;
   pipeline_stall_controller_if #(.CNT_BITS(32)) bus ();
   pipeline_stall_controller #(.MUL_LATENCY(ML), .DMEM_TIMEOUT(DT), .CNT_BITS(32)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   always #5 clk = ~clk;
   typedef struct {
      string      name;
      logic [8:0] in;
      logic [7:0] ctl;
      logic       busy;
      logic       err;
      int         cnt;
   } vec_t;
   vec_t vq[$];
   int n_vec = 0;
   int n_bad = 0;
   // reference model state
   bit m_wait, m_served, m_drop, m_err;
   int m_left, m_waits;
   logic [31:0] m_cnt;

   task automatic add(input string nm, input logic [8:0] in, input logic [7:0] c,
                      input logic b, input logic e, input int n);
      vec_t v;
      v.name = nm; v.in = in; v.ctl = c; v.busy = b; v.err = e; v.cnt = n;
      vq.push_back(v);
   endtask

   // input bits: rst hold id_flush ex_flush branch imem_ready dmem_req dmem_ready mul_start
   task automatic drive(input logic [8:0] in);
      {rst, bus.hold_req, bus.id_flush_req, bus.ex_flush_req, bus.branch_taken,
       bus.imem_ready, bus.dmem_req, bus.dmem_ready, bus.mul_start} = in;
   endtask

   task automatic check(input string nm, input logic [41:0] exp);
      logic [41:0] got;
      got = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
             bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush,
             bus.mul_busy, bus.bus_error, bus.stall_count};
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got ctl=%b busy=%b err=%b cnt=%0d, required ctl=%b busy=%b err=%b cnt=%0d",
                  nm, got[41:34], got[33], got[32], got[31:0], exp[41:34], exp[33], exp[32], exp[31:0]);
      end
   endtask

   // Priority rules applied to the abstract model state; pick names the rule that won.
   task automatic model_eval(input logic [8:0] in, output logic [7:0] c, output int pick);
      bit stalled;
      stalled = m_wait ? !in[1] : (in[2] && !in[1]);
      if (in[8]) begin c = C_RST; pick = 0; end
      else if (stalled) begin c = C_FRZ; pick = 1; end
      else if (m_left > 0) begin c = C_MUL; pick = 2; end
      else if (in[0] && !m_served && ML > 1) begin c = C_MUL; pick = 3; end
      else if (in[5]) begin c = C_MUL; pick = 4; end
      else if (in[7] || in[6]) begin c = C_HLD; pick = 5; end
      else if (in[4]) begin c = C_BR; pick = 6; end
      else if (!in[3] || m_drop) begin c = {in[3], 7'b1111_100}; pick = 7; end
      else begin c = C_RUN; pick = 8; end
   endtask

   task automatic model_commit(input logic [8:0] in, input logic [7:0] c, input int pick);
      if (in[8]) begin
         m_wait = 0; m_served = 0; m_drop = 0; m_err = 0;
         m_left = 0; m_waits = 0; m_cnt = '0;
      end else begin
         if (pick == 1) begin
            m_waits++;
            if (m_waits >= DT - 1) m_err = 1;
            if (m_left == 0) m_wait = 1;
         end else begin
            m_waits = 0;
            m_wait = 0;
         end
         if (c[5] && c[4] && !c[0]) m_served = 0;
         if (pick == 2 || pick == 3) begin
            m_left = (pick == 2) ? m_left - 1 : ML - 2;
            if (m_left == 0) m_served = 1;
         end
         if (pick == 6) m_drop = !in[3];
         if (pick == 7 && in[3]) m_drop = 0;
         if (!c[7] && m_cnt != '1) m_cnt++;
      end
   endtask

   initial begin
      logic [8:0] in;
      logic [7:0] c;
      int pick;
      add("rst_a",      9'b1_1011_0101, C_RST, 0, 0, 0);
      add("rst_b",      9'b1_0100_0011, C_RST, 0, 0, 0);
      add("release",    Q,              C_RUN, 0, 0, 0);
      add("load_use",   9'b0_1000_1000, C_HLD, 0, 0, 0);
      add("after_lu",   Q,              C_RUN, 0, 0, 1);
      add("mul_c1",     9'b0_0000_1001, C_MUL, 0, 0, 1);
      add("mul_c2",     9'b0_0000_1001, C_MUL, 1, 0, 2);
      add("mul_c3",     9'b0_0000_1001, C_MUL, 1, 0, 3);
      add("mul_c4",     9'b0_0000_1001, C_RUN, 0, 0, 4);
      add("mul_done",   Q,              C_RUN, 0, 0, 4);
      for (int k = 0; k < 5; k++) add($sformatf("dwait%0d", k + 1), 9'b0_0000_1100, C_FRZ, 0, 0, 4 + k);
      add("dwait_rdy",  9'b0_0000_1110, C_RUN, 0, 0, 9);
      add("after_dw",   Q,              C_RUN, 0, 0, 9);
      for (int k = 1; k <= 10; k++) add($sformatf("tmo%0d", k), 9'b0_0000_1100, C_FRZ, 0, k >= 8, 8 + k);
      add("tmo_rdy",    9'b0_0000_1110, C_RUN, 0, 1, 19);
      add("tmo_sticky", Q,              C_RUN, 0, 1, 19);
      add("br_fwait",   9'b0_0001_0000, C_BR,  0, 1, 19);
      add("br_drop",    Q,              C_BR,  0, 1, 19);
      add("br_accept",  Q,              C_RUN, 0, 1, 19);
      add("fetch_wait", 9'b0_0000_0000, C_FW,  0, 1, 19);
      add("fetch_ok",   Q,              C_RUN, 0, 1, 20);
      add("ex_flush",   9'b0_0010_1000, C_MUL, 0, 1, 20);
      add("id_flush",   9'b0_0100_1000, C_HLD, 0, 1, 21);
      add("quiet",      Q,              C_RUN, 0, 1, 22);
      add("prio_dw",    9'b0_1000_1101, C_FRZ, 0, 1, 22);
      add("prio_mul",   9'b0_1000_1111, C_MUL, 0, 1, 23);
      add("mul_frz",    9'b0_0000_1101, C_FRZ, 1, 1, 24);
      add("mul_b2",     9'b0_0000_1001, C_MUL, 1, 1, 25);
      add("mul_b3",     9'b0_0000_1001, C_MUL, 1, 1, 26);
      add("mul_end",    9'b0_0000_1001, C_RUN, 0, 1, 27);
      add("rst_mid",    9'b1_0000_1101, C_RST, 0, 0, 0);
      add("post_rst",   Q,              C_RUN, 0, 0, 0);
      foreach (vq[i]) begin
         drive(vq[i].in);
         #1;
         check(vq[i].name, {vq[i].ctl, vq[i].busy, vq[i].err, 32'(vq[i].cnt)});
         @(posedge clk);
         #1;
      end
      for (int i = 0; i < 3000; i++) begin
         in[8] = (i < 2) || ($urandom_range(0, 99) == 0);
         in[7] = $urandom_range(0, 7) == 0;
         in[6] = $urandom_range(0, 15) == 0;
         in[5] = $urandom_range(0, 15) == 0;
         in[4] = $urandom_range(0, 7) == 0;
         in[3] = $urandom_range(0, 3) != 0;
         in[2] = $urandom_range(0, 2) == 0;
         in[1] = $urandom_range(0, 3) == 0;
         in[0] = $urandom_range(0, 3) == 0;
         drive(in);
         #1;
         model_eval(in, c, pick);
         check($sformatf("rand%0d", i),
               {c, !in[8] && m_left > 0, !in[8] && m_err, in[8] ? 32'd0 : m_cnt});
         @(posedge clk);
         model_commit(in, c, pick);
         #1;
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
